// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_REQ    = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-bus read handshake plus the ir valid/ready hand-off to execute.
interface mips_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] instr_address;
   logic              instr_read;
   logic              instr_waitrequest;
   logic [31:0]       instr_readdata;
   logic [31:0]       ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_target;

   modport master (
      output instr_address, instr_read, ir, ir_pc, ir_valid,
      input  instr_waitrequest, instr_readdata, ir_ready, redirect, redirect_target
   );

   modport slave (
      input  instr_address, instr_read, ir, ir_pc, ir_valid,
      output instr_waitrequest, instr_readdata, ir_ready, redirect, redirect_target
   );
endinterface

// File: rtl/mips_fetch_unit_redirect_tracker.sv
// Branch-delay-slot tracking: holds the pending redirect target until the slot
// instruction has been handed off, and flags slot branches / misaligned targets.
module fetch_redirect_tracker
   import mips_fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_xfer,
   input  logic [ADDR_W-1:0] i_ir_pc,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_target,
   output logic [ADDR_W-1:0] o_next_pc,
   output logic              o_err_slot_branch,
   output logic              o_err_misaligned
);
   // r_pend_valid doubles as the delay-slot flag: it is only set by a taken
   // redirect, and the very next transfer is always the slot.
   logic              r_pend_valid;
   logic [ADDR_W-1:0] r_pend_target;
   logic              r_err_slot;
   logic              r_err_mis;
   logic [ADDR_W-1:0] w_seq_pc;

   assign w_seq_pc          = i_ir_pc + ADDR_W'(INSTR_BYTES);
   assign o_next_pc         = r_pend_valid ? r_pend_target : w_seq_pc;
   assign o_err_slot_branch = r_err_slot;
   assign o_err_misaligned  = r_err_mis;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
         r_err_slot    <= 1'b0;
         r_err_mis     <= 1'b0;
      end else if (i_xfer) begin
         if (r_pend_valid) begin
            r_pend_valid <= 1'b0;
            if (i_redirect) begin
               r_err_slot <= 1'b1;
            end
         end else if (i_redirect) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= {i_redirect_target[ADDR_W-1:2], 2'b00};
            if (i_redirect_target[1:0] != 2'b00) begin
               r_err_mis <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC/FSM, stallable read handshake, held ir with
// valid/ready hand-off, halt on HALT_ADDR and saturating retired-instruction count.
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [ADDR_W-1:0] HALT_ADDR    = 32'h00000000,
   parameter int                COUNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_enable,
   mips_fetch_unit_if.master  bus,
   output logic               active,
   output logic               err_slot_branch,
   output logic               err_misaligned,
   output logic [COUNT_W-1:0] instr_count
);
   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_ir_pc;
   logic [31:0]       r_ir;
   logic              r_ir_valid;
   logic [COUNT_W-1:0] r_count;

   logic              w_transfer;
   logic              w_complete;
   logic [ADDR_W-1:0] w_next_pc;

   // Both events already fold in clk_enable so the tracker freezes with the FSM.
   assign w_transfer = clk_enable & (r_state == ST_HOLD) & r_ir_valid & bus.ir_ready;
   assign w_complete = clk_enable & (r_state == ST_REQ) & ~bus.instr_waitrequest;

   fetch_redirect_tracker #(
      .ADDR_W(ADDR_W)
   ) u_tracker (
      .clk               (clk),
      .reset             (reset),
      .i_xfer            (w_transfer),
      .i_ir_pc           (r_ir_pc),
      .i_redirect        (bus.redirect),
      .i_redirect_target (bus.redirect_target),
      .o_next_pc         (w_next_pc),
      .o_err_slot_branch (err_slot_branch),
      .o_err_misaligned  (err_misaligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_VECTOR;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_count    <= '0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               if (clk_enable) begin
                  r_state <= (RESET_VECTOR == HALT_ADDR) ? ST_HALTED : ST_REQ;
               end
            end
            ST_REQ: begin
               if (w_complete) begin
                  r_ir       <= bus.instr_readdata;
                  r_ir_pc    <= r_pc;
                  r_ir_valid <= 1'b1;
                  r_state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_transfer) begin
                  r_ir_valid <= 1'b0;
                  if (r_count != '1) begin
                     r_count <= r_count + 1'b1;
                  end
                  r_pc    <= w_next_pc;
                  r_state <= (w_next_pc == HALT_ADDR) ? ST_HALTED : ST_REQ;
               end
            end
            ST_HALTED: begin
               r_ir_valid <= 1'b0;
            end
            default: r_state <= ST_BOOT;
         endcase
      end
   end

   assign bus.instr_read    = (r_state == ST_REQ);
   assign bus.instr_address = r_pc;
   assign bus.ir            = r_ir;
   assign bus.ir_pc         = r_ir_pc;
   assign bus.ir_valid      = r_ir_valid;
   assign active            = (r_state == ST_REQ) | (r_state == ST_HOLD);
   assign instr_count       = r_count;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: fetch sequencing, stalls, delay slots,
// halt, error flags, clock enable, async reset and counter saturation.
module tb_mips_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b1;
   logic        waitreq = 1'b0;
   logic        active, err_slot_branch, err_misaligned;
   logic [31:0] instr_count;
   int          total = 0;
   int          bad = 0;

   logic        sat_active, sat_err_slot, sat_err_mis;
   logic [1:0]  sat_count;

   mips_fetch_unit_if #(.ADDR_W(32)) bus ();
   mips_fetch_unit_if #(.ADDR_W(32)) sat_bus ();

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'hBFC00000) ? 32'h24020005 : ~a;
   endfunction

   assign bus.instr_readdata    = mem_word(bus.instr_address);
   assign bus.instr_waitrequest = waitreq;

   assign sat_bus.instr_readdata    = 32'h0;
   assign sat_bus.instr_waitrequest = 1'b0;
   assign sat_bus.ir_ready          = 1'b1;
   assign sat_bus.redirect          = 1'b0;
   assign sat_bus.redirect_target   = 32'h0;

   mips_fetch_unit #(
      .ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .HALT_ADDR(32'h00000000), .COUNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus),
      .active(active), .err_slot_branch(err_slot_branch),
      .err_misaligned(err_misaligned), .instr_count(instr_count)
   );

   mips_fetch_unit #(
      .ADDR_W(32), .RESET_VECTOR(32'h00000100), .HALT_ADDR(32'h00000000), .COUNT_W(2)
   ) dut_sat (
      .clk(clk), .reset(reset), .clk_enable(1'b1), .bus(sat_bus),
      .active(sat_active), .err_slot_branch(sat_err_slot),
      .err_misaligned(sat_err_mis), .instr_count(sat_count)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset = 1'b1;
      waitreq = 1'b0;
      clk_enable = 1'b1;
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Waits (bounded) for ir_valid; reports last requested address and cycles waited (-1 on timeout).
   task automatic wait_ir(output logic [31:0] addr, output int n);
      addr = 32'hxxxxxxxx;
      n = -1;
      for (int i = 0; i < 50; i++) begin
         if (bus.instr_read) addr = bus.instr_address;
         if (bus.ir_valid) begin
            n = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic accept(input logic redir, input logic [31:0] tgt);
      bus.ir_ready = 1'b1;
      bus.redirect = redir;
      bus.redirect_target = tgt;
      @(negedge clk);
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
      @(negedge clk);
      total++;
      if (active !== 1'b0 || bus.instr_read !== 1'b0 || bus.ir_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: active=%b read=%b ir_valid=%b, expected 0 0 0", active, bus.instr_read, bus.ir_valid);
      end
      total++;
      if (bus.ir !== 32'h0 || bus.ir_pc !== 32'h0 || instr_count !== 32'h0 ||
          err_slot_branch !== 1'b0 || err_misaligned !== 1'b0) begin
         bad++;
         $display("FAIL reset_regs: ir=%h ir_pc=%h count=%0d errs=%b%b, expected all zero",
                  bus.ir, bus.ir_pc, instr_count, err_slot_branch, err_misaligned);
      end
      reset = 1'b0;
      #1;
      total++;
      if (active !== 1'b0) begin
         bad++;
         $display("FAIL boot_inactive: active=%b, expected 0", active);
      end
      @(negedge clk);
      total++;
      if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00000 || active !== 1'b1) begin
         bad++;
         $display("FAIL first_req: read=%b addr=%h active=%b, expected 1 bfc00000 1",
                  bus.instr_read, bus.instr_address, active);
      end
   endtask

   task automatic test_basic();
      logic [31:0] a;
      int n;
      do_reset();
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00000 || bus.ir !== 32'h24020005 || bus.ir_pc !== 32'hBFC00000) begin
         bad++;
         $display("FAIL basic_first: n=%0d addr=%h ir=%h ir_pc=%h, expected bfc00000 24020005 bfc00000",
                  n, a, bus.ir, bus.ir_pc);
      end
      accept(1'b0, 32'h0);
      total++;
      if (instr_count !== 32'd1 || bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00004) begin
         bad++;
         $display("FAIL basic_next_req: count=%0d read=%b addr=%h, expected 1 1 bfc00004",
                  instr_count, bus.instr_read, bus.instr_address);
      end
      wait_ir(a, n);
      total++;
      if (n !== 1 || bus.ir !== ~32'hBFC00004) begin
         bad++;
         $display("FAIL basic_latency: cycles=%0d ir=%h, expected 1 %h", n, bus.ir, ~32'hBFC00004);
      end
   endtask

   task automatic test_branch();
      logic [31:0] a;
      int n;
      accept(1'b0, 32'h0);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00008) begin
         bad++;
         $display("FAIL branch_pre: addr=%h, expected bfc00008", a);
      end
      accept(1'b1, 32'hBFC00100);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC0000C) begin
         bad++;
         $display("FAIL branch_slot: addr=%h, expected bfc0000c", a);
      end
      accept(1'b0, 32'h0);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00100 || bus.ir !== ~32'hBFC00100 || instr_count !== 32'd4) begin
         bad++;
         $display("FAIL branch_target: addr=%h ir=%h count=%0d, expected bfc00100 %h 4",
                  a, bus.ir, instr_count, ~32'hBFC00100);
      end
   endtask

   task automatic test_halt();
      logic [31:0] a;
      int n;
      accept(1'b1, 32'h00000010);
      wait_ir(a, n);
      accept(1'b0, 32'h0);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'h00000010 || instr_count !== 32'd6) begin
         bad++;
         $display("FAIL halt_reach10: addr=%h count=%0d, expected 00000010 6", a, instr_count);
      end
      accept(1'b1, 32'h00000000);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'h00000014 || bus.ir !== ~32'h00000014) begin
         bad++;
         $display("FAIL halt_slot: addr=%h ir=%h, expected 00000014 %h", a, bus.ir, ~32'h00000014);
      end
      accept(1'b0, 32'h0);
      total++;
      if (active !== 1'b0 || bus.instr_read !== 1'b0 || bus.ir_valid !== 1'b0 || instr_count !== 32'd8) begin
         bad++;
         $display("FAIL halt_state: active=%b read=%b ir_valid=%b count=%0d, expected 0 0 0 8",
                  active, bus.instr_read, bus.ir_valid, instr_count);
      end
      repeat (3) @(negedge clk);
      total++;
      if (active !== 1'b0 || bus.instr_read !== 1'b0) begin
         bad++;
         $display("FAIL halt_sticky: active=%b read=%b, expected 0 0", active, bus.instr_read);
      end
   endtask

   task automatic test_waitrequest();
      reset = 1'b1;
      waitreq = 1'b1;
      bus.ir_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00000 || bus.ir_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_stable[%0d]: read=%b addr=%h ir_valid=%b, expected 1 bfc00000 0",
                     i, bus.instr_read, bus.instr_address, bus.ir_valid);
         end
      end
      waitreq = 1'b0;
      @(negedge clk);
      total++;
      if (bus.ir_valid !== 1'b1 || bus.ir !== 32'h24020005 || bus.instr_read !== 1'b0) begin
         bad++;
         $display("FAIL wait_capture: ir_valid=%b ir=%h read=%b, expected 1 24020005 0",
                  bus.ir_valid, bus.ir, bus.instr_read);
      end
      @(negedge clk);
      total++;
      if (bus.ir_valid !== 1'b1 || bus.instr_read !== 1'b0 || bus.ir_pc !== 32'hBFC00000) begin
         bad++;
         $display("FAIL wait_single: ir_valid=%b read=%b ir_pc=%h, expected 1 0 bfc00000",
                  bus.ir_valid, bus.instr_read, bus.ir_pc);
      end
   endtask

   task automatic test_errors();
      logic [31:0] a;
      int n;
      do_reset();
      wait_ir(a, n);
      accept(1'b1, 32'hBFC00100);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00004) begin
         bad++;
         $display("FAIL err_slot_fetch: addr=%h, expected bfc00004", a);
      end
      accept(1'b1, 32'hBFC00200);
      total++;
      if (err_slot_branch !== 1'b1 || err_misaligned !== 1'b0) begin
         bad++;
         $display("FAIL err_slot_flag: slot=%b mis=%b, expected 1 0", err_slot_branch, err_misaligned);
      end
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00100) begin
         bad++;
         $display("FAIL err_slot_target: addr=%h, expected bfc00100", a);
      end
      accept(1'b1, 32'hBFC00102);
      total++;
      if (err_misaligned !== 1'b1) begin
         bad++;
         $display("FAIL err_mis_flag: mis=%b, expected 1", err_misaligned);
      end
      wait_ir(a, n);
      accept(1'b0, 32'h0);
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00100) begin
         bad++;
         $display("FAIL err_mis_target: addr=%h, expected bfc00100", a);
      end
   endtask

   task automatic test_clk_enable();
      logic [31:0] a;
      int n;
      do_reset();
      wait_ir(a, n);
      clk_enable = 1'b0;
      bus.ir_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_target = 32'hBFC00300;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (bus.ir_valid !== 1'b1 || bus.instr_read !== 1'b0 || bus.ir_pc !== 32'hBFC00000 ||
             instr_count !== 32'd0) begin
            bad++;
            $display("FAIL ce_hold[%0d]: ir_valid=%b read=%b ir_pc=%h count=%0d, expected 1 0 bfc00000 0",
                     i, bus.ir_valid, bus.instr_read, bus.ir_pc, instr_count);
         end
      end
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_target = 32'h0;
      clk_enable = 1'b1;
      accept(1'b0, 32'h0);
      total++;
      if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00004) begin
         bad++;
         $display("FAIL ce_resume: read=%b addr=%h, expected 1 bfc00004", bus.instr_read, bus.instr_address);
      end
      clk_enable = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00004 || bus.ir_valid !== 1'b0) begin
         bad++;
         $display("FAIL ce_req_hold: read=%b addr=%h ir_valid=%b, expected 1 bfc00004 0",
                  bus.instr_read, bus.instr_address, bus.ir_valid);
      end
      clk_enable = 1'b1;
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00004 || bus.ir !== ~32'hBFC00004) begin
         bad++;
         $display("FAIL ce_req_done: addr=%h ir=%h, expected bfc00004 %h", a, bus.ir, ~32'hBFC00004);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] a;
      int n;
      do_reset();
      wait_ir(a, n);
      accept(1'b0, 32'h0);
      waitreq = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (bus.instr_read !== 1'b0 || bus.ir_valid !== 1'b0 || bus.instr_address !== 32'hBFC00000 ||
          instr_count !== 32'd0 || active !== 1'b0) begin
         bad++;
         $display("FAIL midread_reset: read=%b ir_valid=%b addr=%h count=%0d active=%b, expected 0 0 bfc00000 0 0",
                  bus.instr_read, bus.ir_valid, bus.instr_address, instr_count, active);
      end
      @(negedge clk);
      waitreq = 1'b0;
      reset = 1'b0;
      wait_ir(a, n);
      total++;
      if (n < 0 || a !== 32'hBFC00000 || bus.ir !== 32'h24020005) begin
         bad++;
         $display("FAIL midread_refetch: addr=%h ir=%h, expected bfc00000 24020005", a, bus.ir);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (6) @(negedge clk);
      total++;
      if (sat_count !== 2'd2) begin
         bad++;
         $display("FAIL sat_count_mid: count=%0d, expected 2", sat_count);
      end
      repeat (14) @(negedge clk);
      total++;
      if (sat_count !== 2'd3 || sat_active !== 1'b1) begin
         bad++;
         $display("FAIL sat_count_top: count=%0d active=%b, expected 3 1", sat_count, sat_active);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_branch();
      test_halt();
      test_waitrequest();
      test_errors();
      test_clk_enable();
      test_reset_mid_read();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
